// File: rtl/ps02_pkg.sv
// PS02 shared definitions: ALU opcode table, arbiter FSM states and
// the width of the ALU latency counter.
package ps02_pkg;

    localparam int LAT_W = 4;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_ROL   = 4'hA;
    localparam logic [3:0] OP_ROR   = 4'hB;
    localparam logic [3:0] OP_PASSA = 4'hC;
    localparam logic [3:0] OP_PASSB = 4'hD;
    localparam logic [3:0] OP_CMP   = 4'hE;
    localparam logic [3:0] OP_SUB   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ps02_rr_arb2.sv
// Two-way round-robin grant: the requester named by the pointer wins
// when it is valid, otherwise the other valid requester wins.
module ps02_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot grant selection, owner of the pointer has priority
    always_comb begin
        grant = 2'b00;
        if (valid[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (valid[~ptr]) begin
            grant[~ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/ps02_alu_arbiter.sv
// Shares one PS02 ALU between the signal generator (req 0) and the
// host/test port (req 1). One operation is in flight at a time: operands
// are held on alu_* while the ALU works, the result is captured and
// returned on a single tagged response channel.
// Optional grant statistics are enabled with `define PS02_ARB_STATS_EN.
module ps02_alu_arbiter
    import ps02_pkg::*;
#(
    parameter int data_width = 32,
    parameter int ALU_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [data_width-1:0] req0_A,
    input  logic [data_width-1:0] req0_B,
    input  logic [3:0]            req0_op,
    input  logic [data_width-1:0] req1_A,
    input  logic [data_width-1:0] req1_B,
    input  logic [3:0]            req1_op,
    output logic [data_width-1:0] alu_A,
    output logic [data_width-1:0] alu_B,
    output logic [3:0]            alu_op,
    output logic                  alu_start,
    input  logic [data_width-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [data_width-1:0] rsp_data
`ifdef PS02_ARB_STATS_EN
    ,
    output logic [15:0]           gnt_cnt0,
    output logic [15:0]           gnt_cnt1
`endif
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT);
    localparam bit               LAT_ZERO = (ALU_LAT == 0);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             rr_ptr;
    logic             gnt_id;
    logic [1:0]       grant;
    logic             accept;
    logic             capture;
    logic [LAT_W-1:0] wait_cnt;

    ps02_rr_arb2 u_rr_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign accept  = (state == ST_IDLE) && ((req_valid & grant) != 2'b00);
    assign capture = ((state == ST_ISSUE) && LAT_ZERO) ||
                     ((state == ST_WAIT) && (wait_cnt == LAT_W'(1)));
    assign rsp_id  = gnt_id;

    // Next-state logic and per-state handshake/strobe outputs
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (accept) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_start = 1'b1;
                state_nxt = LAT_ZERO ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == LAT_W'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winner's operands and identity at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_A  <= '0;
            alu_B  <= '0;
            alu_op <= OP_NOOP;
            gnt_id <= 1'b0;
        end else if (accept) begin
            alu_A  <= grant[1] ? req1_A  : req0_A;
            alu_B  <= grant[1] ? req1_B  : req0_B;
            alu_op <= grant[1] ? req1_op : req0_op;
            gnt_id <= grant[1];
        end
    end

    // ALU latency counter: loaded in ISSUE, counts down through WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= LAT_LOAD;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - LAT_W'(1);
        end
    end

    // Capture the ALU result on the edge that ends the ALU latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data <= '0;
        end else if (capture) begin
            rsp_data <= alu_result;
        end
    end

    // Hand priority to the other requester once a response is consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if ((state == ST_RESP) && rsp_ready) begin
            rr_ptr <= ~gnt_id;
        end
    end

`ifdef PS02_ARB_STATS_EN
    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept) begin
            if (grant[0] && (gnt_cnt0 != 16'hFFFF)) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (grant[1] && (gnt_cnt1 != 16'hFFFF)) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps02_alu_arbiter.sv
// Bench for ps02_alu_arbiter: three instances (ALU_LAT = 1, 0, 15), each
// fed by a latency-exact behavioural ALU and checked every cycle against a
// transaction-level model. Stats checks compile in with PS02_ARB_STATS_EN.
module tb_ps02_alu_arbiter;
    import ps02_pkg::*;

    localparam int DW = 32;
    localparam int NI = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            OP_NOOP: return a;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a ^ {b[15:0], b[31:16]} ^ {28'h0, op};
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [1:0]    req_valid  [NI];
    logic [1:0]    req_ready  [NI];
    logic [DW-1:0] req0_A     [NI];
    logic [DW-1:0] req0_B     [NI];
    logic [3:0]    req0_op    [NI];
    logic [DW-1:0] req1_A     [NI];
    logic [DW-1:0] req1_B     [NI];
    logic [3:0]    req1_op    [NI];
    logic [DW-1:0] alu_A      [NI];
    logic [DW-1:0] alu_B      [NI];
    logic [3:0]    alu_op     [NI];
    logic          alu_start  [NI];
    logic [DW-1:0] alu_result [NI];
    logic          rsp_valid  [NI];
    logic          rsp_ready  [NI];
    logic          rsp_id     [NI];
    logic [DW-1:0] rsp_data   [NI];
`ifdef PS02_ARB_STATS_EN
    logic [15:0]   gnt_cnt0   [NI];
    logic [15:0]   gnt_cnt1   [NI];
`endif

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : gen_dut
        logic [4:0] since;

        ps02_alu_arbiter #(.data_width(DW), .ALU_LAT(lat_of(i))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[i]),
            .req_ready  (req_ready[i]),
            .req0_A     (req0_A[i]),
            .req0_B     (req0_B[i]),
            .req0_op    (req0_op[i]),
            .req1_A     (req1_A[i]),
            .req1_B     (req1_B[i]),
            .req1_op    (req1_op[i]),
            .alu_A      (alu_A[i]),
            .alu_B      (alu_B[i]),
            .alu_op     (alu_op[i]),
            .alu_start  (alu_start[i]),
            .alu_result (alu_result[i]),
            .rsp_valid  (rsp_valid[i]),
            .rsp_ready  (rsp_ready[i]),
            .rsp_id     (rsp_id[i]),
            .rsp_data   (rsp_data[i])
`ifdef PS02_ARB_STATS_EN
            ,
            .gnt_cnt0   (gnt_cnt0[i]),
            .gnt_cnt1   (gnt_cnt1[i])
`endif
        );

        // Behavioural ALU: result is only correct exactly ALU_LAT cycles after alu_start
        always @(posedge clk or negedge rst) begin
            if (!rst) since <= 5'd0;
            else if (alu_start[i]) since <= 5'd1;
            else if (since != 5'd0 && since != 5'd31) since <= since + 5'd1;
        end

        assign alu_result[i] = ((lat_of(i) == 0) ? alu_start[i] : (int'(since) == lat_of(i)))
                               ? alu_fn(alu_op[i], alu_A[i], alu_B[i])
                               : ~alu_fn(alu_op[i], alu_A[i], alu_B[i]);
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit            m_busy [NI];
    bit            m_ptr  [NI];
    int            m_acc  [NI];
    bit            m_id   [NI];
    logic [DW-1:0] m_a    [NI];
    logic [DW-1:0] m_b    [NI];
    logic [3:0]    m_op   [NI];
    logic [DW-1:0] m_last [NI];
    int            m_cnt0 [NI];
    int            m_cnt1 [NI];

    logic [1:0] acc_mask;
    bit         rsp_done;

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < NI; k++) begin
            m_busy[k] = 0; m_ptr[k] = 0; m_acc[k] = 0; m_id[k] = 0;
            m_a[k] = '0; m_b[k] = '0; m_op[k] = OP_NOOP; m_last[k] = '0;
            m_cnt0[k] = 0; m_cnt1[k] = 0;
        end
    endtask

    task automatic setReq(input int k, input int r, input logic v, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [3:0] op);
        req_valid[k][r] = v;
        if (r == 0) begin
            req0_A[k] = a; req0_B[k] = b; req0_op[k] = op;
        end else begin
            req1_A[k] = a; req1_B[k] = b; req1_op[k] = op;
        end
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input int k);
        checkOutput($sformatf("rst_req_ready%0d", k), req_ready[k], 2'b00);
        checkOutput($sformatf("rst_alu_A%0d", k), alu_A[k], '0);
        checkOutput($sformatf("rst_alu_B%0d", k), alu_B[k], '0);
        checkOutput($sformatf("rst_alu_op%0d", k), alu_op[k], OP_NOOP);
        checkOutput($sformatf("rst_alu_start%0d", k), alu_start[k], 1'b0);
        checkOutput($sformatf("rst_rsp_valid%0d", k), rsp_valid[k], 1'b0);
        checkOutput($sformatf("rst_rsp_id%0d", k), rsp_id[k], 1'b0);
        checkOutput($sformatf("rst_rsp_data%0d", k), rsp_data[k], '0);
    endtask

    // Assert reset asynchronously, check every instance at once, release on a falling edge
    task automatic doReset();
        #2;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 2'b00;
            rsp_ready[k] = 1'b0;
        end
        resetModel();
        #1;
        for (int k = 0; k < NI; k++) checkResetState(k);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle of instance k: compare outputs with the transaction model, then advance it
    task automatic runCycle(input int k);
        logic [1:0] exp_rdy;
        bit         exp_rsp;
        int         lat;
        @(negedge clk);
        cyc++;
        lat      = lat_of(k);
        exp_rdy  = 2'b00;
        acc_mask = 2'b00;
        rsp_done = 0;
        if (!m_busy[k]) begin
            if (req_valid[k][m_ptr[k]]) exp_rdy[m_ptr[k]] = 1'b1;
            else if (req_valid[k][!m_ptr[k]]) exp_rdy[!m_ptr[k]] = 1'b1;
            checkOutput("alu_start_idle", alu_start[k], 1'b0);
            checkOutput("rsp_valid_idle", rsp_valid[k], 1'b0);
            checkOutput("rsp_data_hold", rsp_data[k], m_last[k]);
        end else begin
            exp_rsp = (cyc >= m_acc[k] + lat + 2);
            checkOutput("alu_start", alu_start[k], (cyc == m_acc[k] + 1));
            checkOutput("rsp_valid", rsp_valid[k], exp_rsp);
            if (exp_rsp) begin
                m_last[k] = alu_fn(m_op[k], m_a[k], m_b[k]);
                checkOutput("rsp_id", rsp_id[k], m_id[k]);
                checkOutput("rsp_data", rsp_data[k], m_last[k]);
                if (rsp_ready[k]) begin
                    rsp_done  = 1;
                    m_ptr[k]  = !m_id[k];
                    m_busy[k] = 0;
                end
            end else begin
                checkOutput("rsp_data_hold", rsp_data[k], m_last[k]);
            end
        end
        checkOutput("req_ready", req_ready[k], exp_rdy);
        checkOutput("alu_A", alu_A[k], m_a[k]);
        checkOutput("alu_B", alu_B[k], m_b[k]);
        checkOutput("alu_op", alu_op[k], m_op[k]);
`ifdef PS02_ARB_STATS_EN
        checkOutput("gnt_cnt0", gnt_cnt0[k], m_cnt0[k]);
        checkOutput("gnt_cnt1", gnt_cnt1[k], m_cnt1[k]);
`endif
        if (exp_rdy != 2'b00) begin
            m_busy[k] = 1;
            m_acc[k]  = cyc;
            m_id[k]   = exp_rdy[1];
            m_a[k]    = exp_rdy[1] ? req1_A[k]  : req0_A[k];
            m_b[k]    = exp_rdy[1] ? req1_B[k]  : req0_B[k];
            m_op[k]   = exp_rdy[1] ? req1_op[k] : req0_op[k];
            if (exp_rdy[1]) m_cnt1[k] = (m_cnt1[k] < 65535) ? m_cnt1[k] + 1 : 65535;
            else            m_cnt0[k] = (m_cnt0[k] < 65535) ? m_cnt0[k] + 1 : 65535;
            acc_mask = exp_rdy;
        end
    endtask

    // Random requesters that obey hold-until-accepted, plus random response backpressure
    task automatic applyStimulus(input int k);
        afterEdge();
        for (int r = 0; r < 2; r++) begin
            if (!req_valid[k][r] || acc_mask[r]) begin
                setReq(k, r, ($urandom_range(0, 99) < 60), $urandom, $urandom,
                       4'($urandom_range(0, 15)));
            end
        end
        rsp_ready[k] = ($urandom_range(0, 99) < 70);
    endtask

    // Issue one operation alone and measure accept-to-response latency directly
    task automatic singleOp(input int k, input int r, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [3:0] op,
                            output logic [DW-1:0] data, output logic id);
        int acc_c, rsp_c, starts;
        acc_c = -1; rsp_c = -1; starts = 0; data = '0; id = 1'b0;
        afterEdge();
        setReq(k, r, 1'b1, a, b, op);
        rsp_ready[k] = 1'b1;
        for (int n = 0; n < 25 && rsp_c < 0; n++) begin
            runCycle(k);
            if (alu_start[k]) starts++;
            if (acc_mask[r] && acc_c < 0) acc_c = cyc;
            if (rsp_valid[k] && rsp_c < 0) begin
                rsp_c = cyc; data = rsp_data[k]; id = rsp_id[k];
            end
            afterEdge();
            if (acc_mask[r]) req_valid[k][r] = 1'b0;
        end
        checkOutput($sformatf("latency_lat%0d", lat_of(k)), rsp_c - acc_c, lat_of(k) + 2);
        checkOutput($sformatf("start_pulses_lat%0d", lat_of(k)), starts, 1);
    endtask

    initial begin : main
        logic [DW-1:0] d;
        logic          id;
        int            ids[$];
        logic [DW-1:0] hold_data;
        bit            seen;

        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 2'b00; rsp_ready[k] = 1'b0;
            req0_A[k] = '0; req0_B[k] = '0; req0_op[k] = OP_NOOP;
            req1_A[k] = '0; req1_B[k] = '0; req1_op[k] = OP_NOOP;
        end
        resetModel();
        #13;
        for (int k = 0; k < NI; k++) checkResetState(k);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] single AND op, ALU_LAT=1");
        singleOp(0, 0, 32'h0000BEEF, 32'h00000FF0, OP_AND, d, id);
        checkOutput("t2_rsp_data", d, 32'h00000EE0);
        checkOutput("t2_rsp_id", id, 1'b0);

        $display("[TB] contention from reset");
        doReset();
        afterEdge();
        setReq(0, 0, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
        setReq(0, 1, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
        rsp_ready[0] = 1'b1;
        for (int n = 0; n < 60 && ids.size() < 3; n++) begin
            runCycle(0);
            if (rsp_valid[0] && rsp_ready[0]) ids.push_back(int'(rsp_id[0]));
            afterEdge();
            for (int r = 0; r < 2; r++)
                if (acc_mask[r]) setReq(0, r, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
        checkOutput("t3_rsp_count", ids.size(), 3);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("t3_rsp_id%0d", i), (i < ids.size()) ? ids[i] : 2, i % 2);

        $display("[TB] response backpressure");
        doReset();
        afterEdge();
        setReq(0, 0, 1'b1, $urandom, $urandom, OP_ADD);
        rsp_ready[0] = 1'b0;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            runCycle(0);
            seen = rsp_valid[0];
            afterEdge();
            if (acc_mask[0]) req_valid[0][0] = 1'b0;
        end
        checkOutput("t4_resp_reached", seen, 1'b1);
        setReq(0, 1, 1'b1, $urandom, $urandom, OP_XOR);
        hold_data = rsp_data[0];
        for (int n = 0; n < 5; n++) begin
            runCycle(0);
            checkOutput("t4_hold_data", rsp_data[0], hold_data);
            afterEdge();
        end
        rsp_ready[0] = 1'b1;
        runCycle(0);
        checkOutput("t4_handshake", rsp_done, 1'b1);
        afterEdge();
        runCycle(0);
        checkOutput("t4_req1_accept", req_ready[0], 2'b10);
        afterEdge();
        if (acc_mask[1]) req_valid[0][1] = 1'b0;

        $display("[TB] random traffic, ALU_LAT=1");
        for (int n = 0; n < 300; n++) begin
            runCycle(0);
            applyStimulus(0);
        end
        req_valid[0] = 2'b00;

        for (int k = 1; k < NI; k++) begin
            $display("[TB] latency and random traffic, ALU_LAT=%0d", lat_of(k));
            singleOp(k, 1, $urandom, $urandom, OP_SUB, d, id);
            checkOutput($sformatf("t5_rsp_id_lat%0d", lat_of(k)), id, 1'b1);
            for (int n = 0; n < 150; n++) begin
                runCycle(k);
                applyStimulus(k);
            end
            req_valid[k] = 2'b00;
        end

        $display("[TB] reset during WAIT, ALU_LAT=15");
        doReset();
        afterEdge();
        setReq(2, 0, 1'b1, 32'h12345678, 32'h0F0F0F0F, OP_OR);
        rsp_ready[2] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            runCycle(2);
            afterEdge();
            if (acc_mask[0]) req_valid[2][0] = 1'b0;
        end
        doReset();
        for (int n = 0; n < 25; n++) begin
            runCycle(2);
            checkOutput("t1_no_rsp_after_reset", rsp_valid[2], 1'b0);
        end

`ifdef PS02_ARB_STATS_EN
        $display("[TB] grant statistics");
        doReset();
        for (int n = 0; n < 5; n++) singleOp(0, (n < 3) ? 0 : 1, $urandom, $urandom, OP_ADD, d, id);
        checkOutput("t6_gnt_cnt0", gnt_cnt0[0], 16'd3);
        checkOutput("t6_gnt_cnt1", gnt_cnt1[0], 16'd2);
        force gen_dut[0].u_dut.gnt_cnt0 = 16'hFFFE;
        #1;
        release gen_dut[0].u_dut.gnt_cnt0;
        m_cnt0[0] = 65534;
        for (int n = 0; n < 3; n++) singleOp(0, 0, $urandom, $urandom, OP_ADD, d, id);
        checkOutput("t6_gnt_cnt0_sat", gnt_cnt0[0], 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
